// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    DONE,
    GAP
  } arb_state_e;

  localparam int N_REQ_DEF         = 4;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int START_TIMEOUT_DEF = 64;
  localparam int GAP_CYCLES_DEF    = 8;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module spi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   cand;
  logic [IW-1:0] cand_i;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    cand_i = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      cand_i = cand[IW-1:0];
      if (req[cand_i]) begin
        onehot         = '0;
        onehot[cand_i] = 1'b1;
        idx            = cand_i;
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ byte-transaction requesters.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 SPI_reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_msb,
  input  logic [N_REQ*2-1:0]   req_div,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 m_start,
  output logic [7:0]           m_data_trans,
  output logic                 m_MSB,
  output logic [1:0]           m_div,
  input  logic                 m_flag,
  input  logic [7:0]           m_data_rec
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [7:0] data_arr [N_REQ];
  logic [1:0] div_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*8 +: 8];
    assign div_arr[gi]  = req_div[gi*2 +: 2];
  end

  logic [SYNC_STAGES-1:0] flag_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   flag_s;
  logic [7:0]             data_s;

  always_ff @(posedge clk) begin
    if (SPI_reset) flag_sync_q <= '0;
    else           flag_sync_q <= {flag_sync_q[SYNC_STAGES-2:0], m_flag};
  end

  // Data travels through the same depth as the flag so both are seen coherently.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_dsync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (SPI_reset) data_sync_q[gi] <= 8'h00;
        else           data_sync_q[gi] <= m_data_rec;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (SPI_reset) data_sync_q[gi] <= 8'h00;
        else           data_sync_q[gi] <= data_sync_q[gi-1];
      end
    end
  end

  assign flag_s = flag_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  arb_state_e        state_q;
  logic [N_REQ-1:0]  gnt_q, done_q;
  logic [7:0]        rdata_q, m_data_trans_q;
  logic              err_q, m_start_q, m_msb_q;
  logic [1:0]        m_div_q;
  logic [IW-1:0]     ptr_q, ptr_d, g_q;
  logic [TW-1:0]     tmo_q;
  logic [GW-1:0]     gap_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  spi_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign ptr_d = IW'(wrap_inc(int'(g_q), N_REQ));

  always_ff @(posedge clk) begin
    if (SPI_reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= 1'b0;
      m_start_q      <= 1'b0;
      rdata_q        <= 8'h00;
      m_data_trans_q <= 8'h00;
      m_msb_q        <= 1'b1;
      m_div_q        <= 2'b11;
      ptr_q          <= '0;
      g_q            <= '0;
      tmo_q          <= '0;
      gap_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q          <= pick_onehot;
            g_q            <= pick_idx;
            m_data_trans_q <= data_arr[pick_idx];
            m_msb_q        <= req_msb[pick_idx];
            m_div_q        <= div_arr[pick_idx];
            m_start_q      <= 1'b1;
            tmo_q          <= '0;
            state_q        <= START;
          end
        end
        START: begin
          if (flag_s) begin
            m_start_q <= 1'b0;
            state_q   <= BUSY;
          end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
            m_start_q <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= gnt_q;
            state_q   <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        BUSY: begin
          // Registering done/rdata here makes them visible in the DONE cycle.
          if (!flag_s) begin
            done_q  <= gnt_q;
            rdata_q <= data_s;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          gap_q   <= '0;
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign m_start      = m_start_q;
  assign m_data_trans = m_data_trans_q;
  assign m_MSB        = m_msb_q;
  assign m_div        = m_div_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a behavioural loop-back SPI master model.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        SPI_reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_msb;
  logic [7:0]  req_div;
  logic [3:0]  gnt, done;
  logic [7:0]  rdata, m_data_trans;
  logic        err, m_start, m_MSB;
  logic [1:0]  m_div;
  logic        m_flag = 1'b0;
  logic [7:0]  m_data_rec = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_txn_arbiter dut (
    .clk          (clk),
    .SPI_reset    (SPI_reset),
    .req          (req),
    .req_data     (req_data),
    .req_msb      (req_msb),
    .req_div      (req_div),
    .gnt          (gnt),
    .done         (done),
    .rdata        (rdata),
    .err          (err),
    .m_start      (m_start),
    .m_data_trans (m_data_trans),
    .m_MSB        (m_MSB),
    .m_div        (m_div),
    .m_flag       (m_flag),
    .m_data_rec   (m_data_rec)
  );

  // Master model: flag rises 3 cycles after start, stays 8*(div+1) cycles, then
  // returns the sent byte (mosi looped to miso, same bit order both ways).
  logic       model_en = 1'b1;
  int         ph = 0;
  int         mcnt = 0;
  logic [7:0] mcap = 8'h00;
  logic [1:0] mdiv = 2'b00;

  always @(posedge clk) begin
    if (!model_en) begin
      m_flag <= 1'b0;
      ph     <= 0;
    end else begin
      case (ph)
        0: if (m_start) begin
             mcap <= m_data_trans;
             mdiv <= m_div;
             mcnt <= 0;
             ph   <= 1;
           end
        1: if (mcnt == 2) begin
             m_flag <= 1'b1;
             mcnt   <= 0;
             ph     <= 2;
           end else mcnt <= mcnt + 1;
        2: if (mcnt == 8 * (int'(mdiv) + 1) - 1) begin
             m_flag     <= 1'b0;
             m_data_rec <= mcap;
             ph         <= 3;
           end else mcnt <= mcnt + 1;
        default: if (!m_start) ph <= 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done == 4'b0 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_flag(input logic level);
    int k = 0;
    while (m_flag !== level && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_gnt();
    int k = 0;
    while (gnt == 4'b0 && k < 60) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    SPI_reset = 1'b1; req = '0; req_data = '0; req_msb = '0; req_div = '0;
    repeat (3) tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m_start", m_start, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_m_data_trans", m_data_trans, 8'h00);
    check("rst_m_MSB", m_MSB, 1);
    check("rst_m_div", m_div, 2'b11);
    SPI_reset = 1'b0;
    tick();

    // Single requester, loop-back byte
    req_data[7:0] = 8'hA5; req_msb[0] = 1'b1; req_div[1:0] = 2'b00; req = 4'b0001;
    tick();
    check("t1_gnt_latency", gnt, 4'b0001);
    check("t1_m_data_trans", m_data_trans, 8'hA5);
    check("t1_m_MSB", m_MSB, 1);
    check("t1_m_div", m_div, 2'b00);
    check("t1_m_start", m_start, 1);
    wait_flag(1'b1);
    check("t1_flag_rise", m_flag, 1);
    wait_flag(1'b0);
    n = 0;
    while (done == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("t1_done_after_fall", n, 3);
    check("t1_done", done, 4'b0001);
    check("t1_rdata", rdata, 8'hA5);
    check("t1_err", err, 0);
    req = 4'b0000;
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_gnt_cleared", gnt, 0);
    repeat (12) tick();

    // Start timeout: master never raises flag
    model_en = 1'b0;
    req_data[15:8] = 8'h77; req_div[3:2] = 2'b00; req = 4'b0010;
    tick();
    check("t4_gnt", gnt, 4'b0010);
    wait_done(n);
    check("t4_timeout_cycles", n, 64);
    check("t4_done", done, 4'b0010);
    check("t4_err", err, 1);
    check("t4_rdata_kept", rdata, 8'hA5);
    req = 4'b0000;
    tick();
    check("t4_gnt_cleared", gnt, 0);
    repeat (7) tick();
    check("t4_err_in_gap", err, 1);
    tick();
    check("t4_err_cleared", err, 0);
    model_en = 1'b1;
    repeat (4) tick();

    // Pointer at 2 after serving 1: 0 wins over 1 by wrap-around
    req_data[7:0] = 8'h11; req_data[15:8] = 8'h22;
    req_msb[1:0] = 2'b11; req_div[3:0] = 4'b0000; req = 4'b0011;
    tick();
    check("t3_wrap_gnt", gnt, 4'b0001);
    wait_done(n);
    check("t3_done0", done, 4'b0001);
    check("t3_rdata0", rdata, 8'h11);
    req = 4'b0010;
    tick();
    wait_gnt();
    check("t3_gnt1", gnt, 4'b0010);
    wait_done(n);
    check("t3_done1", done, 4'b0010);
    check("t3_rdata1", rdata, 8'h22);
    req = 4'b0000;
    repeat (12) tick();

    // LSB-first, slowest divider; master inputs stable through BUSY
    req_data[23:16] = 8'h3C; req_msb[2] = 1'b0; req_div[5:4] = 2'b11; req = 4'b0100;
    tick();
    check("t5_gnt", gnt, 4'b0100);
    check("t5_m_div", m_div, 2'b11);
    check("t5_m_MSB", m_MSB, 0);
    wait_flag(1'b1);
    repeat (5) tick();
    check("t5_busy_m_div", m_div, 2'b11);
    check("t5_busy_m_data", m_data_trans, 8'h3C);
    check("t5_busy_m_start", m_start, 0);
    wait_done(n);
    check("t5_done", done, 4'b0100);
    check("t5_rdata", rdata, 8'h3C);
    check("t5_err", err, 0);
    req = 4'b0000;
    repeat (12) tick();

    // All four held from a reset pointer: 0,1,2,3,0
    SPI_reset = 1'b1;
    tick();
    SPI_reset = 1'b0;
    req_data = 32'h13121110; req_msb = 4'b1111; req_div = 8'h00; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      check($sformatf("t2_gnt%0d", k), gnt, exp_g[k]);
      wait_done(n);
      check($sformatf("t2_done%0d", k), done, exp_g[k]);
      check($sformatf("t2_rdata%0d", k), rdata, 8'h10 + (k % 4));
      if (k == 4) req = 4'b0000;
      tick();
    end
    repeat (12) tick();

    // Reset during BUSY, then a fresh request is served
    req_data[31:24] = 8'h5A; req_msb[3] = 1'b1; req_div[7:6] = 2'b01; req = 4'b1000;
    tick();
    check("t6_gnt", gnt, 4'b1000);
    wait_flag(1'b1);
    repeat (5) tick();
    check("t6_busy_gnt", gnt, 4'b1000);
    check("t6_busy_m_start", m_start, 0);
    SPI_reset = 1'b1;
    tick();
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_m_start", m_start, 0);
    check("t6_rst_done", done, 0);
    SPI_reset = 1'b0;
    req = 4'b0000;
    n = 0;
    while ((ph != 0 || m_flag) && n < 100) begin
      tick();
      n++;
    end
    tick();
    req_data[31:24] = 8'hC3; req = 4'b1000;
    tick();
    check("t6_new_gnt", gnt, 4'b1000);
    wait_done(n);
    check("t6_new_done", done, 4'b1000);
    check("t6_new_rdata", rdata, 8'hC3);
    check("t6_new_err", err, 0);
    req = 4'b0000;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
